mem_access_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one single-port 1024x4 storage array among NREQ requesters.

---
 rtl/mem_access_arbiter_pkg.sv | 21 ++
 rtl/mem_access_arbiter_rr_pick.sv | 36 +++
 rtl/mem_access_arbiter.sv | 118 +++++++++++
 tb/tb_mem_access_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the memory access arbiter.
//   arb_state_e  : sequencer states (IDLE, ACCESS, RDWAIT)
//   ARB_*        : default parameter values for the top level
//   wrap_inc     : increment with wrap at n, used for the round-robin pointer
package mem_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2
  } arb_state_e;

  localparam int ARB_NREQ   = 4;
  localparam int ARB_ADDR_W = 10;
  localparam int ARB_DATA_W = 4;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_rr_pick.sv
// Round-robin winner selection (purely combinational).
//   req     : request vector
//   ptr     : index holding highest priority this round
//   winner  : one-hot winner (all zero when req is zero)
//   win_idx : binary index of the winner (0 when req is zero)
// The search starts at ptr and walks upward, wrapping at NREQ.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic [IDX_W-1:0] win_idx
);

  int   j;
  logic found;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found     = 1'b1;
        winner[j] = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter/sequencer in front of a single-port sync-read array.
//   clk, rst   : clock, asynchronous active-high reset
//   req/we     : per-requester request and write flag (req held until gnt)
//   addr/wdata : per-requester operands, packed requester-major
//   gnt        : one-cycle one-hot grant, coincides with the array access
//   rvalid     : one-cycle one-hot read-data-valid, the cycle after a read grant
//   rdata      : read data, meaningful while rvalid is non-zero
//   mem_*      : array port; mem_rdata returns one cycle after a read access
//
// Handshake: a requester raises req with its operands and holds them until
// its gnt bit pulses. Operands are taken only when the sequencer leaves IDLE;
// after that the access completes regardless of req. req still high in the
// cycle after gnt is treated as a fresh request.
//
// Sequence: IDLE (arbitrate, capture) -> ACCESS (gnt + array strobe)
//           -> RDWAIT (reads only: rvalid) -> IDLE.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int NREQ   = ARB_NREQ,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        we,
  input  logic [NREQ*ADDR_W-1:0] addr,
  input  logic [NREQ*DATA_W-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_we;
  logic [DATA_W-1:0] rdata_hold;

  logic [NREQ-1:0]  win_oh;
  logic [IDX_W-1:0] win_idx;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (win_oh),
    .win_idx (win_idx)
  );

  // The array returns read data during RDWAIT itself, so rdata is passed
  // straight through in that state and otherwise shows the registered copy
  // taken at the end of the last RDWAIT. Reset clears both paths at once.
  assign rdata = (state == ST_RDWAIT) ? mem_rdata : rdata_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cur_idx    <= '0;
      cur_we     <= 1'b0;
      gnt        <= '0;
      rvalid     <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata_hold <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            // Outputs for the ACCESS cycle are loaded here so they are
            // registered and appear exactly one cycle after sampling.
            state     <= ST_ACCESS;
            cur_idx   <= win_idx;
            cur_we    <= we[win_idx];
            gnt       <= win_oh;
            mem_en    <= 1'b1;
            mem_we    <= we[win_idx];
            mem_addr  <= addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[win_idx*DATA_W +: DATA_W];
          end
        end
        ST_ACCESS: begin
          gnt    <= '0;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          // The requester just served drops to lowest priority.
          ptr    <= IDX_W'(wrap_inc(int'(cur_idx), NREQ));
          if (cur_we) begin
            state <= ST_IDLE;
          end else begin
            state  <= ST_RDWAIT;
            rvalid <= gnt;  // gnt still holds the winner's one-hot here
          end
        end
        ST_RDWAIT: begin
          rvalid     <= '0;
          rdata_hold <= mem_rdata;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]        req = '0;
  logic [NREQ-1:0]        we = '0;
  logic [NREQ*ADDR_W-1:0] addr = '0;
  logic [NREQ*DATA_W-1:0] wdata = '0;
  logic [NREQ-1:0]        gnt, rvalid;
  logic [DATA_W-1:0]      rdata;
  logic                   mem_en, mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata = '0;

  mem_access_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural 1024x4 sync-read array.
  logic [DATA_W-1:0] arr [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= arr[mem_addr];
    end
  end

  // Reference contents, updated when write stimulus is issued.
  logic [DATA_W-1:0] ref_mem [1024];

  // ---------------- scoreboard ----------------
  // grant record: {idx[1:0], we, addr[9:0], wdata[3:0]}
  logic [16:0] exp_g_q[$];
  // read record: {idx[1:0], data[3:0]}
  logic [5:0]  exp_r_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != '0) begin
        if (exp_g_q.size() == 0) begin
          check("gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          logic [16:0] e;
          e = exp_g_q.pop_front();
          check("gnt_onehot", 32'(gnt), 32'(4'b0001 << e[16:15]));
          check("mem_en", 32'(mem_en), 32'd1);
          check("mem_we", 32'(mem_we), 32'(e[14]));
          check("mem_addr", 32'(mem_addr), 32'(e[13:4]));
          if (e[14]) check("mem_wdata", 32'(mem_wdata), 32'(e[3:0]));
        end
      end else begin
        check("idle_mem_en", 32'({mem_en, mem_we}), 32'd0);
      end
      if (rvalid != '0) begin
        if (exp_r_q.size() == 0) begin
          check("rvalid_unexpected", 32'(rvalid), 32'd0);
        end else begin
          logic [5:0] r;
          r = exp_r_q.pop_front();
          check("rvalid_onehot", 32'(rvalid), 32'(4'b0001 << r[5:4]));
          check("rdata", 32'(rdata), 32'(r[3:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_op(input int i, input bit w, input logic [9:0] a, input logic [3:0] d);
    we[i] = w;
    addr[i*ADDR_W +: ADDR_W] = a;
    wdata[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic push_op(input int i, input bit w, input logic [9:0] a, input logic [3:0] d);
    logic [1:0] ii;
    ii = 2'(i);
    exp_g_q.push_back({ii, w, a, d});
    if (w) ref_mem[a] = d;
    else   exp_r_q.push_back({ii, ref_mem[a]});
  endtask

  // One isolated transaction; the FSM is idle on entry. Checks exact latency.
  task automatic do_single(input int i, input bit w, input logic [9:0] a,
                           input logic [3:0] d, input logic [3:0] e);
    @(negedge clk);
    req = '0;
    set_op(i, w, a, d);
    req[i] = 1'b1;
    push_op(i, w, a, d);
    @(negedge clk);
    check("lat_gnt", 32'(gnt), 32'(4'b0001 << i));
    req = '0;
    @(negedge clk);
    if (!w) begin
      check("lat_rvalid", 32'(rvalid), 32'(4'b0001 << i));
      check("lat_rdata", 32'(rdata), 32'(e));
      @(negedge clk);
      check("rdata_hold", 32'({rvalid, rdata}), 32'({4'b0000, e}));
    end else begin
      check("addr_hold", 32'({mem_en, mem_addr}), 32'({1'b0, a}));
    end
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 30 && (exp_g_q.size() != 0 || exp_r_q.size() != 0); c++)
      @(negedge clk);
    check(name, 32'(exp_g_q.size() + exp_r_q.size()), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         idx;
    bit         w;
    logic [9:0] a;
    logic [3:0] d;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [9];

  initial begin
    bit done;
    int cnt, n0, n2;

    for (int k = 0; k < 1024; k++) begin
      arr[k] = '0;
      ref_mem[k] = '0;
    end

    tbl[0] = '{1, 1'b1, 10'd123,  4'hA, 4'h0};
    tbl[1] = '{1, 1'b0, 10'd123,  4'h0, 4'hA};
    tbl[2] = '{2, 1'b1, 10'd1023, 4'h5, 4'h0};
    tbl[3] = '{0, 1'b1, 10'd0,    4'hC, 4'h0};
    tbl[4] = '{2, 1'b0, 10'd1023, 4'h0, 4'h5};
    tbl[5] = '{0, 1'b0, 10'd0,    4'h0, 4'hC};
    tbl[6] = '{3, 1'b1, 10'd512,  4'hF, 4'h0};
    tbl[7] = '{3, 1'b0, 10'd512,  4'h0, 4'hF};
    tbl[8] = '{1, 1'b0, 10'd123,  4'h0, 4'hA};

    // Power-on reset
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
    rst = 1'b0;

    // Table-driven single transactions
    for (int v = 0; v < 9; v++)
      do_single(tbl[v].idx, tbl[v].w, tbl[v].a, tbl[v].d, tbl[v].exp);

    // Random single transactions on a small address pool
    for (int v = 0; v < 8; v++) begin
      int i;
      bit w;
      logic [9:0] a;
      logic [3:0] d;
      i = $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      a = 10'($urandom_range(200, 207));
      d = 4'($urandom_range(0, 15));
      do_single(i, w, a, d, ref_mem[a]);
    end
    wait_drain("drain_single");

    // Reset in the middle of RDWAIT; ptr is non-zero beforehand
    @(negedge clk);
    set_op(2, 1'b0, 10'd1023, 4'h0);
    req = 4'b0100;
    push_op(2, 1'b0, 10'd1023, 4'h0);
    @(negedge clk);
    req = '0;
    @(negedge clk);  // RDWAIT visible here, consumed by the scoreboard
    #2 rst = 1'b1;
    #1 check("async_reset_outputs",
             32'({gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (rvalid != '0) cnt++;
    end
    check("no_rvalid_after_reset", 32'(cnt), 32'd0);

    // All four hold reads: order 0,1,2,3,0
    set_op(0, 1'b0, 10'd0, 4'h0);
    set_op(1, 1'b0, 10'd123, 4'h0);
    set_op(2, 1'b0, 10'd1023, 4'h0);
    set_op(3, 1'b0, 10'd512, 4'h0);
    push_op(0, 1'b0, 10'd0, 4'h0);
    push_op(1, 1'b0, 10'd123, 4'h0);
    push_op(2, 1'b0, 10'd1023, 4'h0);
    push_op(3, 1'b0, 10'd512, 4'h0);
    push_op(0, 1'b0, 10'd0, 4'h0);
    req = 4'b1111;
    cnt = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (gnt != '0) cnt++;
      if (cnt == 5) begin
        req = '0;
        done = 1'b1;
      end
    end
    check("rr_all_done", 32'(done), 32'd1);
    wait_drain("drain_rr_all");

    // Mixed: req[2] write then read at 1023, req[0] read at 0 (ptr=1)
    @(negedge clk);
    set_op(0, 1'b0, 10'd0, 4'h0);
    set_op(2, 1'b1, 10'd1023, 4'h9);
    push_op(2, 1'b1, 10'd1023, 4'h9);
    push_op(0, 1'b0, 10'd0, 4'h0);
    push_op(2, 1'b0, 10'd1023, 4'h0);
    req = 4'b0101;
    n2 = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (gnt[2]) begin
        n2++;
        if (n2 == 1) we[2] = 1'b0;
        else begin
          req[2] = 1'b0;
          done = 1'b1;
        end
      end
      if (gnt[0]) req[0] = 1'b0;
    end
    check("mixed_done", 32'(done), 32'd1);
    wait_drain("drain_mixed");

    // Withdrawn request: req[3] pulses during another requester's ACCESS
    @(negedge clk);
    set_op(1, 1'b1, 10'd300, 4'h6);
    push_op(1, 1'b1, 10'd300, 4'h6);
    req = 4'b0010;
    @(negedge clk);
    check("withdraw_gnt1", 32'(gnt), 32'b0010);
    set_op(3, 1'b1, 10'd301, 4'h1);
    req = 4'b1000;
    @(negedge clk);
    req = '0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (gnt[3]) cnt++;
    end
    check("withdraw_never_granted", 32'(cnt), 32'd0);
    wait_drain("drain_withdraw");

    // Back-to-back: req[0] held through two grants, req[1] once -> 0,1,0
    @(negedge clk);
    set_op(0, 1'b1, 10'd5, 4'h3);
    set_op(1, 1'b1, 10'd6, 4'h7);
    push_op(0, 1'b1, 10'd5, 4'h3);
    push_op(1, 1'b1, 10'd6, 4'h7);
    push_op(0, 1'b1, 10'd5, 4'h3);
    req = 4'b0011;
    n0 = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (gnt[1]) req[1] = 1'b0;
      if (gnt[0]) begin
        n0++;
        if (n0 == 2) begin
          req[0] = 1'b0;
          done = 1'b1;
        end
      end
    end
    check("b2b_done", 32'(done), 32'd1);
    wait_drain("drain_b2b");
    do_single(2, 1'b0, 10'd5, 4'h0, 4'h3);
    do_single(3, 1'b0, 10'd6, 4'h0, 4'h7);

    wait_drain("drain_final");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
